text_overlay_sequencer: RTL and testbench

//  Frame-rate controller for the "WATERLOO ENG" text overlay generator. Runs a repeating animation:

---
 rtl/overlay_pkg.sv | 34 +++
 rtl/frame_tick_counter.sv | 27 ++
 rtl/text_overlay_sequencer.sv | 166 ++++++++++++++++
 tb/tb_text_overlay_sequencer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/overlay_pkg.sv
// Shared definitions for the text overlay sequencer: state codes, screen geometry and the colour palette.
package overlay_pkg;

    localparam int SCREEN_W     = 640;
    localparam int SCREEN_H     = 480;
    localparam int TEXT_TOTAL_W = 142;

    typedef enum logic [2:0] {
        SEQ_IDLE      = 3'd0,
        SEQ_SLIDE_IN  = 3'd1,
        SEQ_HOLD      = 3'd2,
        SEQ_BLINK     = 3'd3,
        SEQ_SLIDE_OUT = 3'd4,
        SEQ_GAP       = 3'd5
    } seq_state_e;

    // Plain vector codes so the debug port and recovery compare stay legacy-compatible.
    localparam logic [2:0] ST_IDLE      = SEQ_IDLE;
    localparam logic [2:0] ST_SLIDE_IN  = SEQ_SLIDE_IN;
    localparam logic [2:0] ST_HOLD      = SEQ_HOLD;
    localparam logic [2:0] ST_BLINK     = SEQ_BLINK;
    localparam logic [2:0] ST_SLIDE_OUT = SEQ_SLIDE_OUT;
    localparam logic [2:0] ST_GAP       = SEQ_GAP;

    function automatic logic [5:0] palette_rgb(input logic [1:0] idx);
        case (idx)
            2'd0:    return 6'b110110;
            2'd1:    return 6'b111100;
            2'd2:    return 6'b001111;
            default: return 6'b111111;
        endcase
    endfunction

endpackage

// File: rtl/frame_tick_counter.sv
// Frame counter with synchronous clear, tick-enable and terminal-count compare; shared by HOLD, BLINK and GAP.
module frame_tick_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    input  logic [WIDTH-1:0] terminal,
    output logic             tc
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + WIDTH'(1);
        end
    end

    assign tc = (count == terminal);

endmodule

// File: rtl/text_overlay_sequencer.sv
// Frame-rate animation controller for the text overlay: slide in, hold, blink, slide out, gap, repeat.
//
// state     | meaning
// IDLE      | disabled, text hidden at START_X
// SLIDE_IN  | x0 advances STEP per frame up to TARGET_X
// HOLD      | text parked at centre for HOLD_FRAMES
// BLINK     | visibility toggles every BLINK_HALF frames, BLINK_TOGGLES times
// SLIDE_OUT | x0 advances STEP per frame until it would reach EXIT_X
// GAP       | text hidden for GAP_FRAMES, then next colour and restart
module text_overlay_sequencer
    import overlay_pkg::*;
#(
    parameter int STEP          = 4,
    parameter int START_X       = 0,
    parameter int TARGET_X      = SCREEN_W / 2 - TEXT_TOTAL_W / 2,
    parameter int EXIT_X        = SCREEN_W,
    parameter int HOLD_FRAMES   = 120,
    parameter int BLINK_HALF    = 15,
    parameter int BLINK_TOGGLES = 6,
    parameter int GAP_FRAMES    = 60
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_start,
    input  logic       enable,
    output logic       text_visible,
    output logic [9:0] text_x0,
    output logic [5:0] text_rgb,
    output logic       loop_done,
    output logic [2:0] seq_state
);

    if (STEP < 1 || STEP > 383) begin : g_bad_step
        $error("text_overlay_sequencer: STEP must be 1..383");
    end
    if (HOLD_FRAMES < 1 || HOLD_FRAMES > 256 || BLINK_HALF < 1 || BLINK_HALF > 256 ||
        GAP_FRAMES < 1 || GAP_FRAMES > 256) begin : g_bad_frames
        $error("text_overlay_sequencer: frame counts must be 1..256");
    end
    if (BLINK_TOGGLES < 2 || BLINK_TOGGLES > 256 || (BLINK_TOGGLES % 2) != 0) begin : g_bad_toggles
        $error("text_overlay_sequencer: BLINK_TOGGLES must be even and 2..256");
    end

    localparam logic [7:0]  HOLD_TC    = 8'(HOLD_FRAMES - 1);
    localparam logic [7:0]  BLINK_TC   = 8'(BLINK_HALF - 1);
    localparam logic [7:0]  GAP_TC     = 8'(GAP_FRAMES - 1);
    localparam logic [7:0]  TOGGLE_END = 8'(BLINK_TOGGLES - 1);
    localparam logic [9:0]  X_START    = 10'(START_X);
    localparam logic [9:0]  X_TARGET   = 10'(TARGET_X);
    localparam logic [10:0] X_TARGET_W = 11'(TARGET_X);
    localparam logic [10:0] X_EXIT_W   = 11'(EXIT_X);

    logic [2:0]  state;
    logic [1:0]  palette_idx;
    logic [7:0]  blink_cnt;
    logic        tick;
    logic        counting;
    logic        bad_state;
    logic        cnt_clr;
    logic        cnt_inc;
    logic        cnt_tc;
    logic [7:0]  cnt_terminal;
    logic [10:0] x_next;

    assign tick      = frame_start & enable;
    assign bad_state = (state > ST_GAP);
    assign counting  = (state == ST_HOLD) || (state == ST_BLINK) || (state == ST_GAP);
    // 11-bit sum so the clamp and exit compares never see a 10-bit wrap.
    assign x_next    = {1'b0, text_x0} + 11'(STEP);

    always_comb begin
        cnt_terminal = GAP_TC;
        case (state)
            ST_HOLD:  cnt_terminal = HOLD_TC;
            ST_BLINK: cnt_terminal = BLINK_TC;
            default:  cnt_terminal = GAP_TC;
        endcase
    end

    // Counter restarts from zero on every state entry, since each leaving tick clears it.
    assign cnt_inc = tick & counting & ~cnt_tc;
    assign cnt_clr = ~enable | bad_state | (tick & (~counting | cnt_tc));

    frame_tick_counter #(.WIDTH(8)) u_frame_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (cnt_clr),
        .inc      (cnt_inc),
        .terminal (cnt_terminal),
        .tc       (cnt_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            text_visible <= 1'b0;
            text_x0      <= X_START;
            text_rgb     <= palette_rgb(2'd0);
            loop_done    <= 1'b0;
            palette_idx  <= 2'd0;
            blink_cnt    <= 8'd0;
        end else if (!enable || bad_state) begin
            state        <= ST_IDLE;
            text_visible <= 1'b0;
            text_x0      <= X_START;
            loop_done    <= 1'b0;
            blink_cnt    <= 8'd0;
        end else begin
            loop_done <= 1'b0;
            if (frame_start) begin
                case (state)
                    ST_IDLE: begin
                        state        <= ST_SLIDE_IN;
                        text_visible <= 1'b1;
                        text_x0      <= X_START;
                    end
                    ST_SLIDE_IN: begin
                        if (x_next >= X_TARGET_W) begin
                            text_x0 <= X_TARGET;
                            state   <= ST_HOLD;
                        end else begin
                            text_x0 <= x_next[9:0];
                        end
                    end
                    ST_HOLD: begin
                        if (cnt_tc) state <= ST_BLINK;
                    end
                    ST_BLINK: begin
                        if (cnt_tc) begin
                            if (blink_cnt == TOGGLE_END) begin
                                state        <= ST_SLIDE_OUT;
                                text_visible <= 1'b1;
                                blink_cnt    <= 8'd0;
                            end else begin
                                text_visible <= ~text_visible;
                                blink_cnt    <= blink_cnt + 8'd1;
                            end
                        end
                    end
                    ST_SLIDE_OUT: begin
                        if (x_next >= X_EXIT_W) begin
                            text_visible <= 1'b0;
                            state        <= ST_GAP;
                            loop_done    <= 1'b1;
                        end else begin
                            text_x0 <= x_next[9:0];
                        end
                    end
                    ST_GAP: begin
                        if (cnt_tc) begin
                            state        <= ST_SLIDE_IN;
                            text_x0      <= X_START;
                            text_visible <= 1'b1;
                            palette_idx  <= palette_idx + 2'd1;
                            text_rgb     <= palette_rgb(palette_idx + 2'd1);
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign seq_state = state;

endmodule

// File: tb/tb_text_overlay_sequencer.sv
// Randomized bench for text_overlay_sequencer against a timeline-arithmetic reference model.
module tb_text_overlay_sequencer;

    localparam int STEP = 4, START_X = 0, TARGET_X = 249, EXIT_X = 640;
    localparam int HOLD_FRAMES = 120, BLINK_HALF = 15, BLINK_TOGGLES = 6, GAP_FRAMES = 60;

    // Loop timeline in ticks after the IDLE->SLIDE_IN tick.
    localparam int N_IN    = (TARGET_X - START_X + STEP - 1) / STEP;
    localparam int N_MV    = (EXIT_X - STEP - TARGET_X + STEP - 1) / STEP;
    localparam int P_HOLD  = N_IN;
    localparam int P_BLINK = P_HOLD + HOLD_FRAMES;
    localparam int P_OUT   = P_BLINK + BLINK_HALF * BLINK_TOGGLES;
    localparam int P_GAP   = P_OUT + N_MV + 1;
    localparam int LOOP    = P_GAP + GAP_FRAMES;

    logic       clk;
    logic       rst_n;
    logic       frame_start;
    logic       enable;
    logic       text_visible;
    logic [9:0] text_x0;
    logic [5:0] text_rgb;
    logic       loop_done;
    logic [2:0] seq_state;

    int n_checks = 0;
    int n_errors = 0;
    int pal_tab [4];

    bit m_active;
    int m_k;
    int m_base;
    bit m_last_tick;

    text_overlay_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame_start  (frame_start),
        .enable       (enable),
        .text_visible (text_visible),
        .text_x0      (text_x0),
        .text_rgb     (text_rgb),
        .loop_done    (loop_done),
        .seq_state    (seq_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s observed=%0d expected=%0d at t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int exp_pal();
        return m_active ? (m_base + m_k / LOOP) % 4 : m_base;
    endfunction

    function automatic int exp_state();
        int p;
        if (!m_active) return 0;
        p = m_k % LOOP;
        if (p < P_HOLD)  return 1;
        if (p < P_BLINK) return 2;
        if (p < P_OUT)   return 3;
        if (p < P_GAP)   return 4;
        return 5;
    endfunction

    function automatic int exp_x();
        int p;
        if (!m_active) return START_X;
        p = m_k % LOOP;
        if (p < P_HOLD) return START_X + STEP * p;
        if (p < P_OUT)  return TARGET_X;
        if (p < P_GAP)  return TARGET_X + STEP * (p - P_OUT);
        return TARGET_X + STEP * N_MV;
    endfunction

    function automatic int exp_vis();
        int p;
        if (!m_active) return 0;
        p = m_k % LOOP;
        if (p >= P_GAP) return 0;
        if (p >= P_BLINK && p < P_OUT) return (((p - P_BLINK) / BLINK_HALF) % 2 == 0) ? 1 : 0;
        return 1;
    endfunction

    function automatic int exp_ld();
        return (m_active && m_last_tick && (m_k % LOOP) == P_GAP) ? 1 : 0;
    endfunction

    task automatic model_reset();
        m_active = 1'b0; m_k = 0; m_base = 0; m_last_tick = 1'b0;
    endtask

    task automatic model_edge(input bit fs, input bit en);
        if (!en) begin
            m_base = exp_pal();
            m_active = 1'b0; m_k = 0; m_last_tick = 1'b0;
        end else if (fs) begin
            if (!m_active) begin
                m_active = 1'b1; m_k = 0;
            end else begin
                m_k++;
            end
            m_last_tick = 1'b1;
        end else begin
            m_last_tick = 1'b0;
        end
    endtask

    task automatic compare_all();
        check_eq("seq_state", int'(seq_state), exp_state());
        check_eq("text_visible", int'(text_visible), exp_vis());
        check_eq("text_x0", int'(text_x0), exp_x());
        check_eq("text_rgb", int'(text_rgb), pal_tab[exp_pal()]);
        check_eq("loop_done", int'(loop_done), exp_ld());
    endtask

    task automatic step(input bit fs, input bit en);
        frame_start = fs;
        enable      = en;
        @(posedge clk);
        model_edge(fs, en);
        #1;
        compare_all();
    endtask

    // n ticks, each optionally preceded by a quiet cycle to prove non-tick cycles change nothing.
    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 2) == 0) step(1'b0, 1'b1);
            step(1'b1, 1'b1);
        end
    endtask

    initial begin
        pal_tab[0] = 6'b110110; pal_tab[1] = 6'b111100;
        pal_tab[2] = 6'b001111; pal_tab[3] = 6'b111111;
        model_reset();
        rst_n = 1'b0; frame_start = 1'b0; enable = 1'b0;
        #22 rst_n = 1'b1;
        #1;
        compare_all();
        check_eq("reset_rgb", int'(text_rgb), 6'b110110);

        // full first loop
        step(1'b1, 1'b1);
        check_eq("first_state", int'(seq_state), 1);
        check_eq("first_vis", int'(text_visible), 1);
        tick_n(62);
        check_eq("slide_in_248", int'(text_x0), 248);
        tick_n(1);
        check_eq("clamp_249", int'(text_x0), 249);
        check_eq("enter_hold", int'(seq_state), 2);
        tick_n(119);
        check_eq("hold_119", int'(seq_state), 2);
        tick_n(1);
        check_eq("enter_blink", int'(seq_state), 3);
        tick_n(15);
        check_eq("first_toggle", int'(text_visible), 0);
        tick_n(75);
        check_eq("enter_slide_out", int'(seq_state), 4);
        check_eq("slide_out_vis", int'(text_visible), 1);
        tick_n(97);
        check_eq("slide_out_637", int'(text_x0), 637);
        tick_n(1);
        check_eq("loop_done_hi", int'(loop_done), 1);
        check_eq("enter_gap", int'(seq_state), 5);
        check_eq("gap_x0_kept", int'(text_x0), 637);
        step(1'b0, 1'b1);
        check_eq("loop_done_lo", int'(loop_done), 0);
        tick_n(60);
        check_eq("restart_x0", int'(text_x0), 0);
        check_eq("restart_rgb", int'(text_rgb), 6'b111100);

        // disable during BLINK with a simultaneous frame_start
        tick_n(P_BLINK + 5);
        check_eq("mid_blink", int'(seq_state), 3);
        step(1'b1, 1'b0);
        check_eq("disable_idle", int'(seq_state), 0);
        check_eq("disable_rgb_kept", int'(text_rgb), 6'b111100);
        step(1'b1, 1'b1);
        check_eq("reenable_slide_in", int'(seq_state), 1);

        // random frame_start pattern with rare enable drops
        for (int i = 0; i < 5000; i++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 399) != 0);

        // asynchronous reset mid SLIDE_OUT
        for (int i = 0; i < 2000 && seq_state != 3'd4; i++) step(1'b1, 1'b1);
        check_eq("reach_slide_out", int'(seq_state), 4);
        tick_n(3);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_eq("async_state", int'(seq_state), 0);
        check_eq("async_vis", int'(text_visible), 0);
        check_eq("async_x0", int'(text_x0), 0);
        check_eq("async_rgb", int'(text_rgb), 6'b110110);
        #2 rst_n = 1'b1;
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        check_eq("held_fs_x0", int'(text_x0), 8);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
